// File: rtl/grf_param_if.sv
// Register-file port bundle: read ports, byte-enabled write port, issue strobe
// and init status. The master drives addresses and strobes; the register file is the slave.
interface grf_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: there is no valid/ready pair. wr_en and iss_en are single-cycle
    // strobes sampled on the rising edge and always accepted once init_done is
    // high. Reads are combinational and have no handshake.
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH/8-1:0]   wr_be;
    logic [WIDTH-1:0]     wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic                 init_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_be, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, init_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_be, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, init_done
    );
endinterface

// File: rtl/grf_param.sv
// Parametrised register file with write-through forwarding, per-register busy
// scoreboard and a post-reset sweep that clears the array one entry per cycle.
module grf_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    grf_param_if.slave  bus,
    output logic        dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             run;
    logic             wr_ok;

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_v,
                                                     input logic [WIDTH-1:0] new_v,
                                                     input logic [NB-1:0]    be);
        merge_bytes = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merge_bytes[i*8 +: 8] = new_v[i*8 +: 8];
        end
    endfunction

    assign run         = (state_q == ST_RUN);
    assign wr_ok       = run && bus.wr_en && ((ZERO_REG == 0) || (bus.wr_addr != '0));
    assign dbg_state_o = state_q;
    assign bus.init_done = run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Issue after retire: a new producer on the same register overrides the old one.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (bus.wr_en)  busy_d[bus.wr_addr]  = 1'b0;
            if (bus.iss_en) busy_d[bus.iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // The array has no reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q[AW-1:0]] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.wr_addr] <= merge_bytes(mem_q[bus.wr_addr], bus.wr_data, bus.wr_be);
        end
    end

    always_comb begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rv;
        logic             hit;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            ra  = bus.rd_addr[k*AW +: AW];
            hit = bus.wr_en && (bus.wr_addr == ra);
            rv  = mem_q[ra];
            if (hit && wr_ok) rv = merge_bytes(rv, bus.wr_data, bus.wr_be);
            if (!run || ((ZERO_REG != 0) && (ra == '0))) rv = '0;
            bus.rd_data[k*WIDTH +: WIDTH] = rv;
            bus.rd_busy[k] = run && busy_q[ra] && !hit;
        end
    end
endmodule

// File: tb/tb_grf_param.sv
// Bench for grf_param: a 32x32 two-port instance for the main sequences and a
// 16x64 four-port instance for the wide configuration.
module tb_grf_param;
  localparam int W = 66;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  logic dbg_a;
  logic dbg_b;
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[17];

  grf_param_if #(.WIDTH(32), .DEPTH(32), .NRD(2)) bus_a();
  grf_param_if #(.WIDTH(64), .DEPTH(16), .NRD(4)) bus_b();

  grf_param #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a), .dbg_state_o(dbg_a)
  );

  grf_param #(.WIDTH(64), .DEPTH(16), .NRD(4), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b), .dbg_state_o(dbg_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_be = '0; bus_a.wr_data = '0;
    bus_a.iss_en = 1'b0; bus_a.iss_addr = '0; bus_a.rd_addr = '0;
  endtask

  task automatic idle_b();
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_be = '0; bus_b.wr_data = '0;
    bus_b.iss_en = 1'b0; bus_b.iss_addr = '0; bus_b.rd_addr = '0;
  endtask

  task automatic write_b(input logic [3:0] a, input logic [63:0] d);
    bus_b.wr_en = 1'b1; bus_b.wr_addr = a; bus_b.wr_be = 8'hFF; bus_b.wr_data = d;
    @(posedge clk); #1;
    bus_b.wr_en = 1'b0;
  endtask

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [3:0] be, logic [31:0] wd,
                              logic ie, logic [4:0] ia, logic [4:0] ra0, logic [4:0] ra1,
                              logic [31:0] ed0, logic [31:0] ed1, logic [1:0] eb);
    vec_t v;
    v.we = we; v.wa = wa; v.be = be; v.wd = wd; v.ie = ie; v.ia = ia;
    v.ra0 = ra0; v.ra1 = ra1; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    bus_a.wr_en = v.we; bus_a.wr_addr = v.wa; bus_a.wr_be = v.be; bus_a.wr_data = v.wd;
    bus_a.iss_en = v.ie; bus_a.iss_addr = v.ia; bus_a.rd_addr = {v.ra1, v.ra0};
    exp_q.push_back({v.eb, v.ed1, v.ed0});
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_out(input int idx);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL vec%0d: scoreboard queue empty", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("vec%0d rd_data0", idx), {32'h0, bus_a.rd_data[31:0]},  {32'h0, e[31:0]});
      check($sformatf("vec%0d rd_data1", idx), {32'h0, bus_a.rd_data[63:32]}, {32'h0, e[63:32]});
      check($sformatf("vec%0d rd_busy", idx),  {62'h0, bus_a.rd_busy},        {62'h0, e[65:64]});
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 7, 4'hF, 32'hDEADBEEF, 0, 0, 7, 5, 32'hDEADBEEF, 32'h0, 2'b00);
    vecs[1]  = mk(0, 0, 4'h0, 32'h0,        0, 0, 7, 5, 32'hDEADBEEF, 32'h0, 2'b00);
    vecs[2]  = mk(1, 7, 4'h2, 32'h00001200, 0, 0, 7, 5, 32'hDEAD12EF, 32'h0, 2'b00);
    vecs[3]  = mk(0, 0, 4'h0, 32'h0,        0, 0, 7, 7, 32'hDEAD12EF, 32'hDEAD12EF, 2'b00);
    vecs[4]  = mk(1, 0, 4'hF, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0, 32'h0, 2'b00);
    vecs[5]  = mk(0, 0, 4'h0, 32'h0,        0, 0, 0, 0, 32'h0, 32'h0, 2'b00);
    vecs[6]  = mk(0, 0, 4'h0, 32'h0,        1, 9, 9, 9, 32'h0, 32'h0, 2'b00);
    vecs[7]  = mk(0, 0, 4'h0, 32'h0,        0, 0, 9, 9, 32'h0, 32'h0, 2'b11);
    vecs[8]  = mk(1, 9, 4'hF, 32'h12345678, 0, 0, 9, 9, 32'h12345678, 32'h12345678, 2'b00);
    vecs[9]  = mk(0, 0, 4'h0, 32'h0,        0, 0, 9, 9, 32'h12345678, 32'h12345678, 2'b00);
    vecs[10] = mk(1, 9, 4'h1, 32'hA5A5A5A5, 1, 9, 9, 9, 32'h123456A5, 32'h123456A5, 2'b00);
    vecs[11] = mk(0, 0, 4'h0, 32'h0,        0, 0, 9, 7, 32'h123456A5, 32'hDEAD12EF, 2'b01);
    vecs[12] = mk(1, 3, 4'hF, 32'h00000055, 0, 0, 3, 9, 32'h00000055, 32'h123456A5, 2'b10);
    vecs[13] = mk(0, 0, 4'h0, 32'h0,        0, 0, 3, 9, 32'h00000055, 32'h123456A5, 2'b10);
    vecs[14] = mk(1, 9, 4'h0, 32'hFFFFFFFF, 0, 0, 9, 3, 32'h123456A5, 32'h00000055, 2'b00);
    vecs[15] = mk(0, 0, 4'h0, 32'h0,        0, 0, 9, 3, 32'h123456A5, 32'h00000055, 2'b00);
    vecs[16] = mk(0, 0, 4'h0, 32'h0,        1, 9, 3, 9, 32'h00000055, 32'h123456A5, 2'b00);

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    idle_a(); idle_b();
    repeat (2) @(posedge clk); #1;

    check("reset init_done", {63'h0, bus_a.init_done}, 64'h0);
    check("reset rd_data",   bus_a.rd_data, 64'h0);
    check("reset rd_busy",   {62'h0, bus_a.rd_busy}, 64'h0);
    check("reset state",     {63'h0, dbg_a}, 64'h0);

    // Sweep with writes/issues to reg 5 that must be ignored, including the final edge.
    rst_n_a = 1'b1;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_be = 4'hF; bus_a.wr_data = 32'hFFFFFFFF;
    bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd5; bus_a.rd_addr = {5'd5, 5'd5};
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      check($sformatf("init_done after edge %0d", e), {63'h0, bus_a.init_done}, {63'h0, e == 32});
      if (e < 32) check($sformatf("init rd_data edge %0d", e), bus_a.rd_data, 64'h0);
    end
    idle_a();
    for (int a = 0; a < 32; a++) begin
      bus_a.rd_addr = {a[4:0], a[4:0]};
      #2;
      check($sformatf("post-sweep reg %0d", a), bus_a.rd_data, 64'h0);
      check($sformatf("post-sweep busy %0d", a), {62'h0, bus_a.rd_busy}, 64'h0);
    end

    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      drive_vec(vecs[i]);
      @(negedge clk);
      compare_out(i);
      @(posedge clk); #1;
    end
    idle_a();

    // Mid-operation reset: reg 3 holds 0x55, reg 9 is busy.
    bus_a.rd_addr = {5'd9, 5'd3};
    #1;
    check("pre-reset busy",      {62'h0, bus_a.rd_busy}, 64'h2);
    check("pre-reset reg3",      {32'h0, bus_a.rd_data[31:0]}, 64'h55);
    check("pre-reset init_done", {63'h0, bus_a.init_done}, 64'h1);
    rst_n_a = 1'b0;
    #1;
    check("mid-reset init_done", {63'h0, bus_a.init_done}, 64'h0);
    check("mid-reset rd_busy",   {62'h0, bus_a.rd_busy}, 64'h0);
    check("mid-reset rd_data",   bus_a.rd_data, 64'h0);
    @(negedge clk);
    rst_n_a = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      if (e >= 31) check($sformatf("resweep init_done edge %0d", e), {63'h0, bus_a.init_done}, {63'h0, e == 32});
    end
    check("resweep reg3",  {32'h0, bus_a.rd_data[31:0]}, 64'h0);
    check("resweep busy9", {62'h0, bus_a.rd_busy}, 64'h0);

    // Wide four-port instance.
    rst_n_b = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      if (e >= 15) check($sformatf("b init_done edge %0d", e), {63'h0, bus_b.init_done}, {63'h0, e == 16});
    end
    write_b(4'd1,  64'h0123456789ABCDEF);
    write_b(4'd15, 64'hFEDCBA9876543210);
    write_b(4'd0,  64'hFFFFFFFFFFFFFFFF);
    bus_b.rd_addr = {4'd0, 4'd15, 4'd1, 4'd1};
    #1;
    check("b port0 reg1",  bus_b.rd_data[63:0],    64'h0123456789ABCDEF);
    check("b port1 reg1",  bus_b.rd_data[127:64],  64'h0123456789ABCDEF);
    check("b port2 reg15", bus_b.rd_data[191:128], 64'hFEDCBA9876543210);
    check("b port3 reg0",  bus_b.rd_data[255:192], 64'h0);
    check("b rd_busy",     {60'h0, bus_b.rd_busy}, 64'h0);

    check("scoreboard drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
